hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Watches the decode-stage sources and the outputs of the ID/EX register (opcode, destination, MemRD, RegWrite), and drives the enable/flush controls back into PC, IF/ID and ID/EX.
- Inserts load-use bubbles, holds the pipe for multi-cycle execute ops, and flushes on taken branches.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- NOP_OPCODE, 5'b11111, opcode the ID/EX register holds after flush; identifies a bubble.
- MUL_OPCODE, 5'b01010, execute opcode needing MUL_CYCLES cycles in EX.
- MUL_CYCLES, 4, EX occupancy of MUL_OPCODE; legal 2..16.
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; legal 1..3 (2 when MEM forwarding absent).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IdRs1  in  5  decode source register 1.
- IdRs2  in  5  decode source register 2.
- IdUsesRs1  in  1  decode instruction reads IdRs1.
- IdUsesRs2  in  1  decode instruction reads IdRs2.
- ExOpcode  in  5  OPCODE output of ID/EX.
- ExRd  in  5  RD output of ID/EX.
- ExMemRd  in  1  MEMRD output of ID/EX (load in EX).
- ExRegWrite  in  1  REGWRITE output of ID/EX.
- BranchTaken  in  1  taken branch/jump resolved in EX this cycle.
- PcEnable  out  1  PC update enable.
- IfIdEnable  out  1  IF/ID register enable.
- IfIdFlush  out  1  IF/ID clear.
- IdExEnable  out  1  ID/EX Enable.
- IdExFlush  out  1  ID/EX Reset (inserts NOP_OPCODE bubble).
- ExStall  out  1  EX unit busy / hold.
- StallCycles  out  16  saturating count of cycles with PcEnable=0.

Behaviour:
- Outputs are Mealy: combinational from registered state plus current inputs. State, counter, MulDone and StallCycles are registered.
- States:
  - RUN: free flow.
  - LOAD_STALL: bubbles still owed.
  - MULTI: multi-cycle op occupying EX.
- Registered count cnt is 4 bits.
- Async Reset (any time, including mid-stall):
  - state=RUN, cnt=0, MulDone=0, StallCycles=0.
  - Outputs immediately take their RUN, no-hazard values: PcEnable=IfIdEnable=IdExEnable=1, flushes=0, ExStall=0.
- Hazard definitions:
  - LoadUse = ExMemRd & ExRegWrite & (ExRd!=0) & ((IdUsesRs1 & IdRs1==ExRd) | (IdUsesRs2 & IdRs2==ExRd)).
  - MulHit = (ExOpcode==MUL_OPCODE) & ~MulDone.
- RUN priority, highest first:
  1. MulHit: PcEnable=IfIdEnable=IdExEnable=0, ExStall=1. Next state MULTI, cnt=MUL_CYCLES-2. BranchTaken and LoadUse are ignored this cycle.
  2. BranchTaken: IfIdFlush=1, IdExFlush=1, enables all 1. Stay RUN. LoadUse is ignored because the decode instruction is squashed.
  3. LoadUse: PcEnable=IfIdEnable=0, IdExFlush=1. If LOAD_BUBBLES>1, next state LOAD_STALL with cnt=LOAD_BUBBLES-2; else stay RUN.
  4. Otherwise: all enables 1, no flush.
- LOAD_STALL:
  - PcEnable=IfIdEnable=0, IdExFlush=1.
  - cnt decrements each cycle; at cnt==0, next state RUN.
  - BranchTaken cannot occur, since EX holds a bubble, and is ignored.
- MULTI:
  - PcEnable=IfIdEnable=IdExEnable=0, ExStall=1.
  - cnt decrements each cycle; at cnt==0, next state RUN and MulDone←1.
  - Total stall is exactly MUL_CYCLES-1 cycles, so the op spends MUL_CYCLES cycles in EX.
- MulDone:
  - Set on MULTI exit.
  - Cleared on any edge where IdExEnable=1 and state is RUN, i.e. the op advances out of EX.
  - Purpose: the same MUL is not retriggered in the cycle it is released.
  - Back-to-back MULs each stall: the second arrives after MulDone has cleared.
- Flushed ID/EX yields ExOpcode=NOP_OPCODE with ExMemRd=0, so a bubble never triggers a hazard.
- StallCycles:
  - Increments on each rising edge where PcEnable=0.
  - Saturates at 16'hFFFF; no wrap.

Test Plan:
- Reset asserted mid-MULTI (cnt=1), without waiting for a clock edge → outputs immediately PcEnable=1, ExStall=0, StallCycles=0; after release, normal flow.
- ExMemRd=1, ExRegWrite=1, ExRd=5, IdRs2=5, IdUsesRs2=1, LOAD_BUBBLES=1 → exactly 1 cycle with PcEnable=0, IdExFlush=1; then ExOpcode=5'b11111 and no further stall. Repeat with ExRd=0 → no stall.
- LOAD_BUBBLES=2, same hazard → 2 consecutive bubble cycles; StallCycles advances by 2.
- ExOpcode=MUL_OPCODE, MUL_CYCLES=4 → ExStall=1 for 3 cycles, 4th cycle IdExEnable=1 with no retrigger. A following MUL stalls again for 3 cycles.
- BranchTaken=1 coincident with LoadUse in RUN → IfIdFlush=IdExFlush=1, PcEnable=1, no load stall. BranchTaken=1 during MULTI → ignored.
- Force 65540 stall cycles → StallCycles holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, multi-cycle EX hold,
// taken-branch flush, and a saturating stall-cycle performance counter.
module hazard_ctrl #(
    parameter logic [4:0] NOP_OPCODE   = 5'b11111,
    parameter logic [4:0] MUL_OPCODE   = 5'b01010,
    parameter int         MUL_CYCLES   = 4,
    parameter int         LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [4:0]  IdRs1,
    input  logic [4:0]  IdRs2,
    input  logic        IdUsesRs1,
    input  logic        IdUsesRs2,
    input  logic [4:0]  ExOpcode,
    input  logic [4:0]  ExRd,
    input  logic        ExMemRd,
    input  logic        ExRegWrite,
    input  logic        BranchTaken,
    output logic        PcEnable,
    output logic        IfIdEnable,
    output logic        IfIdFlush,
    output logic        IdExEnable,
    output logic        IdExFlush,
    output logic        ExStall,
    output logic [15:0] StallCycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MULTI      = 2'd2
    } state_t;

    localparam logic [3:0] MUL_INIT  = 4'(MUL_CYCLES - 2);
    localparam logic [3:0] LOAD_INIT = 4'(LOAD_BUBBLES - 2);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       mul_done;
    logic       mul_set;
    logic       load_use;
    logic       mul_hit;

    // A bubble (NOP_OPCODE) in EX is never a producer, even if its MEMRD bit is stale.
    assign load_use = ExMemRd && ExRegWrite && (ExRd != 5'd0) && (ExOpcode != NOP_OPCODE) &&
                      ((IdUsesRs1 && (IdRs1 == ExRd)) || (IdUsesRs2 && (IdRs2 == ExRd)));
    assign mul_hit  = (ExOpcode == MUL_OPCODE) && !mul_done;

    // NOTE: every output and next-state signal gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        mul_set    = 1'b0;
        PcEnable   = 1'b1;
        IfIdEnable = 1'b1;
        IfIdFlush  = 1'b0;
        IdExEnable = 1'b1;
        IdExFlush  = 1'b0;
        ExStall    = 1'b0;
        if (!Reset) begin
            unique case (state)
                RUN: begin
                    if (mul_hit) begin
                        PcEnable   = 1'b0;
                        IfIdEnable = 1'b0;
                        IdExEnable = 1'b0;
                        ExStall    = 1'b1;
                        // A two-cycle op is released after this single stall cycle.
                        if (MUL_CYCLES > 2) begin
                            state_n = MULTI;
                            cnt_n   = MUL_INIT;
                        end else begin
                            mul_set = 1'b1;
                        end
                    end else if (BranchTaken) begin
                        IfIdFlush = 1'b1;
                        IdExFlush = 1'b1;
                    end else if (load_use) begin
                        PcEnable   = 1'b0;
                        IfIdEnable = 1'b0;
                        IdExFlush  = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_n = LOAD_STALL;
                            cnt_n   = LOAD_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    PcEnable   = 1'b0;
                    IfIdEnable = 1'b0;
                    IdExFlush  = 1'b1;
                    if (cnt == 4'd0) begin
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                MULTI: begin
                    PcEnable   = 1'b0;
                    IfIdEnable = 1'b0;
                    IdExEnable = 1'b0;
                    ExStall    = 1'b1;
                    // Leave as the counter reaches zero so the total hold is MUL_CYCLES-1.
                    if (cnt <= 4'd1) begin
                        state_n = RUN;
                        cnt_n   = 4'd0;
                        mul_set = 1'b1;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            mul_done    <= 1'b0;
            StallCycles <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (mul_set) begin
                mul_done <= 1'b1;
            end else if ((state == RUN) && IdExEnable) begin
                mul_done <= 1'b0;
            end
            if (!PcEnable && (StallCycles != 16'hFFFF)) begin
                StallCycles <= StallCycles + 16'd1;
            end
        end
    end

endmodule
